// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the round-robin / manual stream multiplexer.
package stream_mux_pkg;

    typedef enum logic {
        MODE_RR     = 1'b0,
        MODE_MANUAL = 1'b1
    } mode_e;

    localparam int DATA_MAX = 1024;
    localparam int W_MAX    = 64;

    // Flattened bus is zero-extended to DATA_MAX; caller truncates to W.
    function automatic logic [W_MAX-1:0] ch_slice(
        input logic [DATA_MAX-1:0] data,
        input int                  w,
        input int                  i
    );
        return W_MAX'(data >> (i * w));
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin arbiter; owns the priority pointer (last served channel).
module rr_arbiter #(
    parameter int N_CH = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  req,
    input  logic             advance,
    input  logic [SEL_W-1:0] grant_idx_in,
    output logic [SEL_W-1:0] ptr,
    output logic             grant_valid,
    output logic [SEL_W-1:0] grant_idx
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= SEL_W'(N_CH - 1);
        end else if (advance) begin
            ptr <= grant_idx_in;
        end
    end

    // Scan from farthest to nearest so the nearest requester after ptr wins.
    always_comb begin : search
        int               idx;
        logic [SEL_W-1:0] idx_s;
        idx         = 0;
        idx_s       = '0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = N_CH; k >= 1; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N_CH) idx = idx - N_CH;
            idx_s = SEL_W'(idx);
            if (req[idx_s]) begin
                grant_valid = 1'b1;
                grant_idx   = idx_s;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with round-robin or manual selection
// and a single registered output stage.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int W    = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic [SEL_W-1:0]  sel,
    input  logic [N_CH-1:0]   in_valid,
    input  logic [N_CH*W-1:0] in_data,
    output logic [N_CH-1:0]   in_ready,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic [SEL_W-1:0]  out_ch,
    input  logic              out_ready
);

    logic             can_load;
    logic             rr_valid;
    logic [SEL_W-1:0] rr_idx;
    logic [SEL_W-1:0] ptr;
    logic             man_valid;
    logic             grant_valid;
    logic [SEL_W-1:0] g;
    logic             load;
    logic [W-1:0]     g_data;

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .clk          (clk),
        .rst          (rst),
        .req          (in_valid),
        .advance      (load),
        .grant_idx_in (g),
        .ptr          (ptr),
        .grant_valid  (rr_valid),
        .grant_idx    (rr_idx)
    );

    assign can_load  = (!out_valid || out_ready) && !rst;
    assign man_valid = ({1'b0, sel} < (SEL_W+1)'(N_CH)) && in_valid[sel];

    always_comb begin
        grant_valid = rr_valid;
        g           = rr_idx;
        if (mode == MODE_MANUAL) begin
            grant_valid = man_valid;
            g           = sel;
        end
    end

    assign load   = can_load && grant_valid;
    assign g_data = W'(ch_slice(DATA_MAX'(in_data), W, int'(g)));

    always_comb begin
        in_ready = '0;
        if (load) in_ready[g] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= g_data;
            out_ch    <= g;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed table-driven bench for stream_mux_rr (N_CH=4, W=4).
module tb_stream_mux_rr;

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] iv;
        logic       ordy;
        logic [3:0] eir;
        logic       eov;
        logic [1:0] ech;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  in_valid;
    logic [15:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [3:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_ready;

    int n_pass  = 0;
    int n_total = 0;

    vec_t vecs[$];

    stream_mux_rr #(.N_CH(4), .W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic add(input logic m, input logic [1:0] s,
                       input logic [3:0] iv, input logic ordy,
                       input logic [3:0] eir, input logic eov,
                       input logic [1:0] ech);
        vec_t v;
        v.mode = m; v.sel = s; v.iv = iv; v.ordy = ordy;
        v.eir = eir; v.eov = eov; v.ech = ech;
        vecs.push_back(v);
    endtask

    initial begin
        vec_t v;
        rst       = 1'b1;
        mode      = 1'b0;
        sel       = 2'd0;
        in_valid  = 4'b1111;
        in_data   = {4'hD, 4'hC, 4'hB, 4'hA};
        out_ready = 1'b1;

        // 1: RR all valid
        add(0, 0, 4'b1111, 1, 4'b0001, 1, 0);
        add(0, 0, 4'b1111, 1, 4'b0010, 1, 1);
        add(0, 0, 4'b1111, 1, 4'b0100, 1, 2);
        add(0, 0, 4'b1111, 1, 4'b1000, 1, 3);
        add(0, 0, 4'b1111, 1, 4'b0001, 1, 0);
        add(0, 0, 4'b1111, 1, 4'b0010, 1, 1);
        // 2: back-pressure holding ch1
        add(0, 0, 4'b1111, 0, 4'b0000, 1, 1);
        add(0, 0, 4'b1111, 0, 4'b0000, 1, 1);
        add(0, 0, 4'b1111, 0, 4'b0000, 1, 1);
        add(0, 0, 4'b1111, 1, 4'b0100, 1, 2);
        // 3: sparse wrap
        add(0, 0, 4'b1111, 1, 4'b1000, 1, 3);
        add(0, 0, 4'b1111, 1, 4'b0001, 1, 0);
        add(0, 0, 4'b1000, 1, 4'b1000, 1, 3);
        add(0, 0, 4'b1010, 1, 4'b0010, 1, 1);
        add(0, 0, 4'b1010, 1, 4'b1000, 1, 3);
        // 4: manual
        add(1, 2, 4'b0110, 1, 4'b0100, 1, 2);
        add(1, 2, 4'b0110, 1, 4'b0100, 1, 2);
        add(1, 3, 4'b0110, 1, 4'b0000, 0, 0);
        add(1, 3, 4'b0110, 1, 4'b0000, 0, 0);
        // 5: mode switch
        add(1, 2, 4'b1111, 1, 4'b0100, 1, 2);
        add(0, 2, 4'b1111, 1, 4'b1000, 1, 3);
        add(0, 2, 4'b1111, 1, 4'b0001, 1, 0);
        add(0, 2, 4'b1111, 1, 4'b0010, 1, 1);
        add(0, 2, 4'b1111, 1, 4'b0100, 1, 2);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 4'h0);
        chk("rst_out_ch", out_ch, 2'd0);
        chk("rst_in_ready", in_ready, 4'b0000);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            v         = vecs[i];
            mode      = v.mode;
            sel       = v.sel;
            in_valid  = v.iv;
            out_ready = v.ordy;
            #1;
            chk($sformatf("v%0d_in_ready", i), in_ready, v.eir);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", i), out_valid, v.eov);
            if (v.eov) begin
                chk($sformatf("v%0d_out_ch", i), out_ch, v.ech);
                chk($sformatf("v%0d_out_data", i), out_data,
                    4'hA + {2'b00, v.ech});
            end
        end

        // 6: async reset between edges while a word is held
        chk("pre_rst_valid", out_valid, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        chk("async_out_valid", out_valid, 1'b0);
        chk("async_out_data", out_data, 4'h0);
        chk("async_out_ch", out_ch, 2'd0);
        chk("async_in_ready", in_ready, 4'b0000);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        mode      = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 4'b0001);
        @(posedge clk);
        #1;
        chk("post_rst_valid", out_valid, 1'b1);
        chk("post_rst_ch", out_ch, 2'd0);
        chk("post_rst_data", out_data, 4'hA);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
